// File: rtl/exec_unit_alu_if.sv
// ---------------------------------------------------------------------------
// exec_unit_alu_if
//
// Purpose: bundles the dispatch port (reservation station -> ALU) and the
// result port (ALU -> common-data-bus arbiter) of the integer execution unit.
//
// Handshake semantics (both ports):
//   dispatch: an instruction transfers on a rising clk edge when
//             dispatch_valid && dispatch_ack are both high in that cycle.
//             dispatch_ack is combinational and may only be high when
//             dispatch_valid is high. The producer holds op/operands/tag
//             stable while dispatch_valid is high and dispatch_ack is low.
//   result:   the head result transfers (is popped) on a rising clk edge
//             when res_valid && res_grant are both high. res_tag/res_data
//             stay stable while res_valid is high and res_grant is low.
//
// Signals:
//   dispatch_valid, dispatch_op[2:0], dispatch_val1[31:0],
//   dispatch_val2[31:0], dispatch_dest_tag[TAG_WIDTH-1:0]   master -> slave
//   dispatch_ack                                            slave -> master
//   res_valid, res_tag[TAG_WIDTH-1:0], res_data[31:0]       slave -> master
//   res_grant                                               master -> slave
//
// Modports:
//   master - the reservation station / CDB arbiter side
//   slave  - the execution unit
// ---------------------------------------------------------------------------
interface exec_unit_alu_if #(
    parameter int TAG_WIDTH = 6
);
    logic                 dispatch_valid;
    logic [2:0]           dispatch_op;
    logic [31:0]          dispatch_val1;
    logic [31:0]          dispatch_val2;
    logic [TAG_WIDTH-1:0] dispatch_dest_tag;
    logic                 dispatch_ack;

    logic                 res_valid;
    logic [TAG_WIDTH-1:0] res_tag;
    logic [31:0]          res_data;
    logic                 res_grant;

    modport master (
        output dispatch_valid,
        output dispatch_op,
        output dispatch_val1,
        output dispatch_val2,
        output dispatch_dest_tag,
        input  dispatch_ack,
        input  res_valid,
        input  res_tag,
        input  res_data,
        output res_grant
    );

    modport slave (
        input  dispatch_valid,
        input  dispatch_op,
        input  dispatch_val1,
        input  dispatch_val2,
        input  dispatch_dest_tag,
        output dispatch_ack,
        output res_valid,
        output res_tag,
        output res_data,
        input  res_grant
    );
endinterface

// File: rtl/exec_unit_alu.sv
// ---------------------------------------------------------------------------
// exec_unit_alu
//
// Purpose: integer functional unit behind the reservation-station dispatch
// port. Accepts one ready instruction per handshake, computes the result and
// holds it in a small in-order result FIFO until the CDB arbiter grants a
// broadcast slot. Results leave in acceptance order.
//
// Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL,
//          111 MUL (low 32 bits of unsigned product). Shifts use B[4:0].
//
// Configuration macro: EXEC_UNIT_MUL_EN
//   defined     - opcode 111 is a multi-cycle multiplier run by a small
//                 IDLE/MUL FSM; dispatch is blocked while it runs.
//   not defined - no multiplier; opcode 111 completes in one cycle with a
//                 zero result and eu_busy is tied low.
//
// Parameters:
//   TAG_WIDTH   ROB tag width
//   RES_DEPTH   result FIFO entries (power of two, >= 1)
//   MUL_LATENCY accept-to-buffered-result cycles for MUL (>= 2)
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   bus        exec_unit_alu_if.slave: dispatch and result handshakes
//   flush      discards an in-flight MUL and every buffered result
//   eu_busy    MUL in progress
//   res_count  number of buffered results
//   fsm_state  debug view of the MUL FSM (0 = IDLE, 1 = MUL)
// ---------------------------------------------------------------------------
module exec_unit_alu #(
    parameter int TAG_WIDTH   = 6,
    parameter int RES_DEPTH   = 2,
    parameter int MUL_LATENCY = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    exec_unit_alu_if.slave             bus,
    input  logic                       flush,
    output logic                       eu_busy,
    output logic [$clog2(RES_DEPTH):0] res_count,
    output logic                       fsm_state
);

    localparam int CNT_W = $clog2(RES_DEPTH) + 1;
    // A depth of 1 still needs a 1-bit pointer; it simply never leaves 0.
    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

    typedef logic [PTR_W-1:0] ptr_t;

    localparam ptr_t             LAST_PTR  = ptr_t'(RES_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RES_DEPTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    // -----------------------------------------------------------------------
    // Result FIFO state
    // -----------------------------------------------------------------------
    logic [TAG_WIDTH-1:0] tag_mem  [RES_DEPTH];
    logic [31:0]          data_mem [RES_DEPTH];
    ptr_t                 rd_ptr;
    ptr_t                 wr_ptr;
    logic [CNT_W-1:0]     count;

    logic                 accept;
    logic                 push;
    logic                 pop;
    logic [TAG_WIDTH-1:0] push_tag;
    logic [31:0]          push_data;
    logic [31:0]          alu_res;
    logic                 buf_valid;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == LAST_PTR) ? '0 : ptr_t'(p + 1'b1);
    endfunction

    // -----------------------------------------------------------------------
    // Acceptance. Space is judged on the registered count only, so a pop in
    // the same cycle never makes room for a new instruction.
    // -----------------------------------------------------------------------
    assign accept = bus.dispatch_valid && !eu_busy && (count < DEPTH_CNT)
                    && !flush && !rst;
    assign bus.dispatch_ack = accept;

    // -----------------------------------------------------------------------
    // Single-cycle ALU
    // -----------------------------------------------------------------------
    always_comb begin
        alu_res = '0;
        unique case (bus.dispatch_op)
            OP_ADD:  alu_res = bus.dispatch_val1 + bus.dispatch_val2;
            OP_SUB:  alu_res = bus.dispatch_val1 - bus.dispatch_val2;
            OP_AND:  alu_res = bus.dispatch_val1 & bus.dispatch_val2;
            OP_OR:   alu_res = bus.dispatch_val1 | bus.dispatch_val2;
            OP_XOR:  alu_res = bus.dispatch_val1 ^ bus.dispatch_val2;
            OP_SLL:  alu_res = bus.dispatch_val1 << bus.dispatch_val2[4:0];
            OP_SRL:  alu_res = bus.dispatch_val1 >> bus.dispatch_val2[4:0];
            // MUL goes through the multiplier when it exists; otherwise it
            // completes here with a zero result.
            OP_MUL:  alu_res = '0;
            default: alu_res = '0;
        endcase
    end

`ifdef EXEC_UNIT_MUL_EN
    // -----------------------------------------------------------------------
    // Multi-cycle multiplier
    // -----------------------------------------------------------------------
    localparam int LAT_W = $clog2(MUL_LATENCY) + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [LAT_W-1:0]     lat_cnt;
    logic [31:0]          mul_a;
    logic [31:0]          mul_b;
    logic [TAG_WIDTH-1:0] mul_tag;
    logic                 mul_start;
    logic                 mul_done;
    logic [31:0]          mul_prod;

    assign mul_start = accept && (bus.dispatch_op == OP_MUL);

    // State register
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (mul_start)                state_nxt = ST_MUL;
            ST_MUL:  if (lat_cnt == LAT_W'(1))     state_nxt = ST_IDLE;
            default:                               state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        eu_busy   = 1'b0;
        mul_done  = 1'b0;
        fsm_state = 1'b0;
        if (state == ST_MUL) begin
            eu_busy   = 1'b1;
            fsm_state = 1'b1;
            // The result is pushed at the edge that ends the count==1 cycle,
            // so res_valid rises MUL_LATENCY cycles after acceptance.
            mul_done  = (lat_cnt == LAT_W'(1));
        end
    end

    // Latency counter and operand latches
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            lat_cnt <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            mul_tag <= '0;
        end else if (mul_start) begin
            lat_cnt <= LAT_W'(MUL_LATENCY - 1);
            mul_a   <= bus.dispatch_val1;
            mul_b   <= bus.dispatch_val2;
            mul_tag <= bus.dispatch_dest_tag;
        end else if (state == ST_MUL) begin
            lat_cnt <= lat_cnt - 1'b1;
        end
    end

    assign mul_prod = mul_a * mul_b;

    // A completing MUL and a new acceptance never coincide: acceptance needs
    // eu_busy low, and mul_done only occurs while busy.
    assign push      = (accept && !mul_start) || mul_done;
    assign push_tag  = mul_done ? mul_tag  : bus.dispatch_dest_tag;
    assign push_data = mul_done ? mul_prod : alu_res;
`else
    assign eu_busy   = 1'b0;
    assign fsm_state = 1'b0;
    assign push      = accept;
    assign push_tag  = bus.dispatch_dest_tag;
    assign push_data = alu_res;
`endif

    // -----------------------------------------------------------------------
    // Result FIFO
    // -----------------------------------------------------------------------
    assign buf_valid = (count != '0);
    assign pop       = buf_valid && bus.res_grant && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            tag_mem[wr_ptr]  <= push_tag;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign bus.res_valid = buf_valid;
    assign bus.res_tag   = buf_valid ? tag_mem[rd_ptr]  : '0;
    assign bus.res_data  = buf_valid ? data_mem[rd_ptr] : '0;
    assign res_count     = count;

endmodule

// File: tb/tb_exec_unit_alu.sv
// ---------------------------------------------------------------------------
// tb_exec_unit_alu
//
// Directed bench for exec_unit_alu. A reference model (FIFO of expected
// {tag,data} entries plus a MUL countdown) is checked against the DUT every
// cycle; directed scenarios add hand-computed literal expectations.
// Multiplier scenarios follow EXEC_UNIT_MUL_EN.
// ---------------------------------------------------------------------------
module tb_exec_unit_alu;

    localparam int TW          = 6;
    localparam int RES_DEPTH   = 2;
    localparam int MUL_LATENCY = 3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    logic flush;
    logic eu_busy;
    logic [$clog2(RES_DEPTH):0] res_count;
    logic fsm_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exec_unit_alu_if #(.TAG_WIDTH(TW)) bus ();

    exec_unit_alu #(
        .TAG_WIDTH  (TW),
        .RES_DEPTH  (RES_DEPTH),
        .MUL_LATENCY(MUL_LATENCY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .flush    (flush),
        .eu_busy  (eu_busy),
        .res_count(res_count),
        .fsm_state(fsm_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    logic [TW+31:0] exp_q[$];
    logic [TW+31:0] mul_ent;
    int             mul_left = 0;
    logic           acc_now;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_ack();
        return bus.dispatch_valid && (mul_left == 0) && (exp_q.size() < RES_DEPTH)
               && !flush && !rst;
    endfunction

    // Model advances on each rising edge using the inputs of the ending cycle.
    always @(posedge clk) begin
        acc_now = model_ack();
        if (rst || flush) begin
            exp_q.delete();
            mul_left = 0;
        end else begin
            if (bus.res_grant && exp_q.size() > 0) void'(exp_q.pop_front());
            if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) exp_q.push_back(mul_ent);
            end
            if (acc_now) begin
`ifdef EXEC_UNIT_MUL_EN
                if (bus.dispatch_op == OP_MUL) begin
                    mul_ent  = {bus.dispatch_dest_tag, bus.dispatch_val1 * bus.dispatch_val2};
                    mul_left = MUL_LATENCY - 1;
                end else
`endif
                exp_q.push_back({bus.dispatch_dest_tag,
                                 ref_result(bus.dispatch_op, bus.dispatch_val1, bus.dispatch_val2)});
            end
        end
    end

    // Compare process: mid-cycle, against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_ack",       32'(bus.dispatch_ack), 32'(model_ack()));
            chk("cmp_res_valid", 32'(bus.res_valid),    32'(exp_q.size() > 0));
            chk("cmp_res_count", 32'(res_count),        32'(exp_q.size()));
            chk("cmp_eu_busy",   32'(eu_busy),          32'(mul_left > 0));
            chk("cmp_fsm_state", 32'(fsm_state),        32'(mul_left > 0));
            if (exp_q.size() > 0) begin
                chk("cmp_res_tag",  32'(bus.res_tag), 32'(exp_q[0][TW+31:32]));
                chk("cmp_res_data", bus.res_data,     exp_q[0][31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TW-1:0] tag);
        bus.dispatch_valid    = v;
        bus.dispatch_op       = op;
        bus.dispatch_val1     = a;
        bus.dispatch_val2     = b;
        bus.dispatch_dest_tag = tag;
        #1;
    endtask

    // Back-to-back table with hand-computed results.
    logic [2:0]    tv_op  [8] = '{OP_SLL, OP_SRL, OP_ADD, OP_SUB, OP_OR, OP_XOR, OP_SLL, OP_SRL};
    logic [31:0]   tv_a   [8] = '{32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,
                                  32'h1234_0000, 32'hAAAA_5555, 32'h8000_0001, 32'hFFFF_FFFF};
    logic [31:0]   tv_b   [8] = '{32'd35, 32'd31, 32'h2, 32'h1,
                                  32'h0000_5678, 32'hFFFF_0000, 32'h0, 32'd32};
    logic [31:0]   tv_exp [8] = '{32'h8, 32'h1, 32'h1, 32'hFFFF_FFFF,
                                  32'h1234_5678, 32'h5555_5555, 32'h8000_0001, 32'hFFFF_FFFF};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.res_grant = 1'b0;
        drive(1'b1, OP_ADD, 32'd1, 32'd1, 6'd1);

        // Reset: outputs zero, no acceptance even with valid high.
        tick();
        chk_en = 1'b1;
        chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
        chk("rst_res_tag",   32'(bus.res_tag),   32'h0);
        chk("rst_res_data",  bus.res_data,       32'h0);
        chk("rst_res_count", 32'(res_count),     32'h0);
        chk("rst_eu_busy",   32'(eu_busy),       32'h0);
        chk("rst_ack",       32'(bus.dispatch_ack), 32'h0);
        tick();
        rst = 1'b0;
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 6'd0);
        tick();

        // ADD 5+7, tag 3, grant held high.
        bus.res_grant = 1'b1;
        drive(1'b1, OP_ADD, 32'd5, 32'd7, 6'd3);
        chk("add_ack", 32'(bus.dispatch_ack), 32'h1);
        tick();
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 6'd0);
        chk("add_valid", 32'(bus.res_valid), 32'h1);
        chk("add_data",  bus.res_data,       32'd12);
        chk("add_tag",   32'(bus.res_tag),   32'd3);
        tick();
        chk("add_drained", 32'(res_count), 32'h0);

        // Fill the buffer with grant low; third dispatch must stall.
        bus.res_grant = 1'b0;
        drive(1'b1, OP_SUB, 32'd1, 32'd2, 6'd1);
        chk("fill_ack1", 32'(bus.dispatch_ack), 32'h1);
        tick();
        drive(1'b1, OP_XOR, 32'hF0F0_0000, 32'h0000_F0F0, 6'd2);
        chk("fill_ack2", 32'(bus.dispatch_ack), 32'h1);
        tick();
        drive(1'b1, OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 6'd4);
        chk("fill_ack3_low", 32'(bus.dispatch_ack), 32'h0);
        chk("fill_count",    32'(res_count),        32'd2);
        tick();
        chk("fill_hold_data", bus.res_data, 32'hFFFF_FFFF);
        bus.res_grant = 1'b1;
        #1;
        chk("pop_no_free_ack", 32'(bus.dispatch_ack), 32'h0);
        chk("pop1_tag",        32'(bus.res_tag),      32'd1);
        tick();
        chk("pop2_count", 32'(res_count),        32'd1);
        chk("pop2_data",  bus.res_data,          32'hF0F0_F0F0);
        chk("pop2_tag",   32'(bus.res_tag),      32'd2);
        chk("pop2_ack",   32'(bus.dispatch_ack), 32'h1);
        tick();
        chk("and_data",  bus.res_data,     32'h0F00_0F00);
        chk("and_tag",   32'(bus.res_tag), 32'd4);
        chk("and_count", 32'(res_count),   32'd1);
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 6'd0);
        tick();
        chk("fill_drained", 32'(res_count), 32'h0);

        // Back-to-back single-cycle ops including shift and wrap boundaries.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tv_op[i], tv_a[i], tv_b[i], 6'(5 + i));
            chk("b2b_ack", 32'(bus.dispatch_ack), 32'h1);
            tick();
            chk("b2b_data", bus.res_data,     tv_exp[i]);
            chk("b2b_tag",  32'(bus.res_tag), 32'(5 + i));
        end
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 6'd0);
        tick();

`ifdef EXEC_UNIT_MUL_EN
        // MUL blocks dispatch for MUL_LATENCY-1 cycles.
        drive(1'b1, OP_MUL, 32'h0001_0000, 32'h0001_0001, 6'd9);
        chk("mul_ack", 32'(bus.dispatch_ack), 32'h1);
        tick();
        drive(1'b1, OP_ADD, 32'd1, 32'd1, 6'd10);
        for (int i = 0; i < MUL_LATENCY - 1; i++) begin
            chk("mul_block_ack", 32'(bus.dispatch_ack), 32'h0);
            chk("mul_busy",      32'(eu_busy),          32'h1);
            tick();
        end
        chk("mul_valid",    32'(bus.res_valid),    32'h1);
        chk("mul_data",     bus.res_data,          32'h0001_0000);
        chk("mul_tag",      32'(bus.res_tag),      32'd9);
        chk("mul_idle",     32'(eu_busy),          32'h0);
        chk("mul_next_ack", 32'(bus.dispatch_ack), 32'h1);
        tick();
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 6'd0);
        chk("mul_next_data", bus.res_data, 32'd2);
        tick();
`else
        // Without multiplier op 111 is a single-cycle zero.
        drive(1'b1, OP_MUL, 32'd3, 32'd4, 6'd30);
        chk("nomul_ack", 32'(bus.dispatch_ack), 32'h1);
        tick();
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 6'd0);
        chk("nomul_valid", 32'(bus.res_valid), 32'h1);
        chk("nomul_data",  bus.res_data,       32'h0);
        chk("nomul_tag",   32'(bus.res_tag),   32'd30);
        chk("nomul_busy",  32'(eu_busy),       32'h0);
        tick();
`endif

        // Flush with one buffered result (and a running MUL when present).
        bus.res_grant = 1'b0;
        drive(1'b1, OP_ADD, 32'd2, 32'd3, 6'd11);
        tick();
`ifdef EXEC_UNIT_MUL_EN
        drive(1'b1, OP_MUL, 32'd6, 32'd7, 6'd12);
        chk("fl_mul_ack", 32'(bus.dispatch_ack), 32'h1);
        tick();
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 6'd0);
        chk("fl_busy_before", 32'(eu_busy), 32'h1);
        chk("fl_count_before", 32'(res_count), 32'd1);
`else
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 6'd0);
        chk("fl_count_before", 32'(res_count), 32'd1);
`endif
        flush = 1'b1;
        drive(1'b1, OP_ADD, 32'd9, 32'd9, 6'd14);
        chk("fl_ack_low", 32'(bus.dispatch_ack), 32'h0);
        tick();
        flush = 1'b0;
        drive(1'b1, OP_ADD, 32'd40, 32'd2, 6'd13);
        chk("fl_valid", 32'(bus.res_valid), 32'h0);
        chk("fl_count", 32'(res_count),     32'h0);
        chk("fl_busy",  32'(eu_busy),       32'h0);
        chk("fl_new_ack", 32'(bus.dispatch_ack), 32'h1);
        tick();
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 6'd0);
        for (int i = 0; i < MUL_LATENCY + 1; i++) begin
            chk("fl_only_add_count", 32'(res_count), 32'd1);
            chk("fl_only_add_data",  bus.res_data,   32'd42);
            tick();
        end
        bus.res_grant = 1'b1;
        tick();
        chk("fl_final_count", 32'(res_count), 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
